tank_hit_detector: RTL and testbench

Per-frame bullet-versus-tank collision detector and health tracker. It produces the one-frame `bull_collide_flag` pulse and the 4-bit `health` value consumed by the hit-text overlay logic. It also produces `bullet_consume`, which despawns the bullet that hit, and manages the tank's destroyed/respawn lifecycle. It runs on `frame_clk` alongside the tank and bullet motion blocks.

---
 rtl/tank_hit_detector.sv | 123 ++++++++++++
 tb/tb_tank_hit_detector.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/tank_hit_detector.sv
// tank_hit_detector: per-frame bullet/tank collision, health tracking and destroy/respawn lifecycle.
// Optional invulnerability window after a non-fatal hit: define TANK_HIT_COOLDOWN_EN. Rev 1.0
`default_nettype none

module tank_hit_detector #(
  parameter logic [3:0] MAX_HEALTH      = 4'd3,
  parameter logic [3:0] HIT_DAMAGE      = 4'd1,
  parameter logic [9:0] TANK_HALF       = 10'd16,
  parameter logic [9:0] BULLET_HALF     = 10'd2,
  parameter logic [9:0] COOLDOWN_FRAMES = 10'd60,
  parameter logic [9:0] RESPAWN_FRAMES  = 10'd180
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] Tank_X,
  input  logic [9:0] Tank_Y,
  input  logic [9:0] Bullet_X,
  input  logic [9:0] Bullet_Y,
  input  logic       bullet_active,
  output logic       bull_collide_flag,
  output logic [3:0] health,
  output logic       bullet_consume,
  output logic       tank_destroyed,
  output logic       respawn_pulse
);

  localparam logic [1:0] ST_ALIVE     = 2'd0;
`ifdef TANK_HIT_COOLDOWN_EN
  localparam logic [1:0] ST_COOLDOWN  = 2'd1;
`endif
  localparam logic [1:0] ST_DESTROYED = 2'd2;

  localparam logic [10:0] HIT_REACH = {1'b0, TANK_HALF} + {1'b0, BULLET_HALF};

  logic [1:0]         state;
  logic [9:0]         frame_cnt;
  logic [9:0]         cnt_last;
  logic               cnt_done;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic [10:0]        abs_dx;
  logic [10:0]        abs_dy;
  logic               overlap;
  logic [3:0]         next_health;

  // Zero-extend before subtracting so the 11-bit signed difference never overflows.
  assign dx     = $signed({1'b0, Bullet_X}) - $signed({1'b0, Tank_X});
  assign dy     = $signed({1'b0, Bullet_Y}) - $signed({1'b0, Tank_Y});
  assign abs_dx = dx[10] ? 11'(-dx) : 11'(dx);
  assign abs_dy = dy[10] ? 11'(-dy) : 11'(dy);

  assign overlap = bullet_active && (abs_dx <= HIT_REACH) && (abs_dy <= HIT_REACH);

  assign next_health = (health > HIT_DAMAGE) ? (health - HIT_DAMAGE) : 4'd0;

  // One shared frame counter serves both timed states.
  assign cnt_last = (state == ST_DESTROYED) ? (RESPAWN_FRAMES - 10'd1)
                                            : (COOLDOWN_FRAMES - 10'd1);
  assign cnt_done = (frame_cnt == cnt_last);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state             <= ST_ALIVE;
      frame_cnt         <= 10'd0;
      health            <= MAX_HEALTH;
      bull_collide_flag <= 1'b0;
      bullet_consume    <= 1'b0;
      tank_destroyed    <= 1'b0;
      respawn_pulse     <= 1'b0;
    end else begin
      bull_collide_flag <= 1'b0;
      bullet_consume    <= 1'b0;
      respawn_pulse     <= 1'b0;
      case (state)
        ST_ALIVE: begin
          if (overlap) begin
            health            <= next_health;
            bull_collide_flag <= 1'b1;
            bullet_consume    <= 1'b1;
            frame_cnt         <= 10'd0;
            if (next_health == 4'd0) begin
              state          <= ST_DESTROYED;
              tank_destroyed <= 1'b1;
            end
`ifdef TANK_HIT_COOLDOWN_EN
            else begin
              state <= ST_COOLDOWN;
            end
`endif
          end
        end
`ifdef TANK_HIT_COOLDOWN_EN
        ST_COOLDOWN: begin
          if (cnt_done) begin
            state     <= ST_ALIVE;
            frame_cnt <= 10'd0;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
`endif
        ST_DESTROYED: begin
          if (cnt_done) begin
            state          <= ST_ALIVE;
            frame_cnt      <= 10'd0;
            health         <= MAX_HEALTH;
            tank_destroyed <= 1'b0;
            respawn_pulse  <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 10'd1;
          end
        end
        default: begin
          state     <= ST_ALIVE;
          frame_cnt <= 10'd0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tank_hit_detector.sv
// tb_tank_hit_detector: directed scoreboard bench for tank_hit_detector (default and TANK_HIT_COOLDOWN_EN builds).
`default_nettype none

module tb_tank_hit_detector;

  typedef struct packed {
    logic       flag;
    logic       consume;
    logic [3:0] health;
    logic       destroyed;
    logic       respawn;
  } exp_t;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [9:0] Tank_X, Tank_Y, Bullet_X, Bullet_Y;
  logic       bullet_active;
  logic       bullet_active5;
  logic       bull_collide_flag, bullet_consume, tank_destroyed, respawn_pulse;
  logic [3:0] health;
  logic       flag5, consume5, destroyed5, respawn5;
  logic [3:0] health5;

  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  exp_t sb[$];

  always #5 frame_clk = ~frame_clk;

  tank_hit_detector dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .Tank_X(Tank_X), .Tank_Y(Tank_Y), .Bullet_X(Bullet_X), .Bullet_Y(Bullet_Y),
    .bullet_active(bullet_active),
    .bull_collide_flag(bull_collide_flag), .health(health), .bullet_consume(bullet_consume),
    .tank_destroyed(tank_destroyed), .respawn_pulse(respawn_pulse)
  );

  tank_hit_detector #(.HIT_DAMAGE(4'd5)) dut5 (
    .frame_clk(frame_clk), .Reset(Reset),
    .Tank_X(Tank_X), .Tank_Y(Tank_Y), .Bullet_X(Bullet_X), .Bullet_Y(Bullet_Y),
    .bullet_active(bullet_active5),
    .bull_collide_flag(flag5), .health(health5), .bullet_consume(consume5),
    .tank_destroyed(destroyed5), .respawn_pulse(respawn5)
  );

  function automatic exp_t mk(input logic f, input logic c, input logic [3:0] h,
                              input logic d, input logic r);
    exp_t e;
    e.flag = f; e.consume = c; e.health = h; e.destroyed = d; e.respawn = r;
    return e;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  // Drive one frame of stimulus, queue its expected outputs, compare after the edge.
  task automatic step(input logic [9:0] tx, input logic [9:0] ty, input logic [9:0] bx,
                      input logic [9:0] by, input logic act, input exp_t e);
    exp_t got;
    Tank_X = tx; Tank_Y = ty; Bullet_X = bx; Bullet_Y = by; bullet_active = act;
    sb.push_back(e);
    @(posedge frame_clk);
    #1;
    step_no++;
    got = sb.pop_front();
    check("flag",      16'(bull_collide_flag), 16'(got.flag));
    check("consume",   16'(bullet_consume),    16'(got.consume));
    check("health",    16'(health),            16'(got.health));
    check("destroyed", 16'(tank_destroyed),    16'(got.destroyed));
    check("respawn",   16'(respawn_pulse),     16'(got.respawn));
  endtask

  // Assert reset between edges and check that it takes effect without a clock.
  task automatic do_reset();
    Reset = 1'b1;
    #2;
    check("async_rst_health",  16'(health),            16'd3);
    check("async_rst_flag",    16'(bull_collide_flag), 16'd0);
    check("async_rst_destroy", 16'(tank_destroyed),    16'd0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    Tank_X = 10'd100; Tank_Y = 10'd100; Bullet_X = 10'd0; Bullet_Y = 10'd0;
    bullet_active = 1'b0;
    bullet_active5 = 1'b0;
    repeat (2) @(posedge frame_clk);
    #1;
    check("rst_health",  16'(health),            16'd3);
    check("rst_flag",    16'(bull_collide_flag), 16'd0);
    check("rst_consume", 16'(bullet_consume),    16'd0);
    check("rst_destroy", 16'(tank_destroyed),    16'd0);
    check("rst_respawn", 16'(respawn_pulse),     16'd0);
    Reset = 1'b0;

    // Overlapping but inactive bullet: no hit
    step(10'd100, 10'd100, 10'd118, 10'd100, 1'b0, mk(0, 0, 4'd3, 0, 0));

    // Edge-contact hit; the HIT_DAMAGE=5 instance saturates to 0 and is destroyed
    bullet_active5 = 1'b1;
    step(10'd100, 10'd100, 10'd118, 10'd100, 1'b1, mk(1, 1, 4'd2, 0, 0));
    bullet_active5 = 1'b0;
    check("dmg5_flag",    16'(flag5),      16'd1);
    check("dmg5_health",  16'(health5),    16'd0);
    check("dmg5_destroy", 16'(destroyed5), 16'd1);

    do_reset();

    // One pixel beyond reach on each axis/side: no hit
    step(10'd100, 10'd100, 10'd119, 10'd100, 1'b1, mk(0, 0, 4'd3, 0, 0));
    step(10'd100, 10'd100, 10'd100, 10'd119, 1'b1, mk(0, 0, 4'd3, 0, 0));
    step(10'd100, 10'd100, 10'd81,  10'd100, 1'b1, mk(0, 0, 4'd3, 0, 0));
    // Negative-dy edge contact
    step(10'd100, 10'd100, 10'd100, 10'd82,  1'b1, mk(1, 1, 4'd2, 0, 0));

`ifdef TANK_HIT_COOLDOWN_EN
    // Held overlap: masked for 60 frames, then accepted, then masked again
    for (int i = 0; i <= 120; i++) begin
      step(10'd100, 10'd100, 10'd100, 10'd82, (i < 70),
           mk((i == 60), (i == 60), (i < 60) ? 4'd2 : 4'd1, 0, 0));
    end
`else
    step(10'd100, 10'd100, 10'd100, 10'd82, 1'b1, mk(1, 1, 4'd1, 0, 0));
`endif

    // Fatal hit, then overlap ignored throughout DESTROYED
    step(10'd100, 10'd100, 10'd110, 10'd90, 1'b1, mk(1, 1, 4'd0, 1, 0));
    for (int i = 1; i < 180; i++) begin
      step(10'd100, 10'd100, 10'd110, 10'd90, 1'b1, mk(0, 0, 4'd0, 1, 0));
    end
    step(10'd100, 10'd100, 10'd110, 10'd90, 1'b1, mk(0, 0, 4'd3, 0, 1));
    // First ALIVE frame after respawn accepts a hit
    step(10'd100, 10'd100, 10'd110, 10'd90, 1'b1, mk(1, 1, 4'd2, 0, 0));

    // Reset mid-COOLDOWN (or mid-operation): back to ALIVE, next overlap is a hit
    do_reset();
    step(10'd300, 10'd200, 10'd290, 10'd210, 1'b1, mk(1, 1, 4'd2, 0, 0));
    step(10'd300, 10'd200, 10'd0,   10'd0,   1'b1, mk(0, 0, 4'd2, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
